// File: rtl/uart_tx_fifo.sv
// Transmit FIFO and sequencer feeding uart_tx. It buffers host bytes and launches
// one frame at a time, waiting for tx_done_tick before it pops the next byte.
module uart_tx_fifo #(
    parameter int DBITS      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DBITS-1:0]      w_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    input  logic                  clr_ovf,
    output logic [DBITS-1:0]      din,
    output logic                  tx_start,
    input  logic                  tx_done_tick,
    output logic                  busy
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [DBITS-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [1:0]            state_q, state_d;
    logic [DBITS-1:0]      din_q, din_d;
    logic                  tx_start_q, tx_start_d;
    logic                  ovf_q, ovf_d;
    logic                  wr_ok, pop;

    // Flags come from the registered count, so a same-cycle pop never frees room
    // for a write into a full FIFO, and a fresh write cannot be popped at once.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign wr_ok = wr && !full;
    assign pop   = (state_q == ST_IDLE) && !empty;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        din_d      = din_q;
        tx_start_d = 1'b0;
        ovf_d      = ovf_q;

        if (wr_ok)
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);

        case ({wr_ok, pop})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase

        // A dropped write outranks a simultaneous clear.
        if (wr && full)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    din_d      = mem[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (tx_done_tick)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_IDLE;
            din_q      <= '0;
            tx_start_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            din_q      <= din_d;
            tx_start_q <= tx_start_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr_q] <= w_data;
    end

    assign count    = count_q;
    assign overflow = ovf_q;
    assign din      = din_q;
    assign tx_start = tx_start_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo; tx_done_tick is driven by hand in place of uart_tx.
module tb_uart_tx_fifo;
    logic       clk = 1'b0;
    logic       reset;
    logic       wr;
    logic [7:0] w_data;
    logic       full, empty, overflow, clr_ovf, tx_start, tx_done_tick, busy;
    logic [4:0] count;
    logic [7:0] din;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(.DBITS(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .wr(wr), .w_data(w_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow),
        .clr_ovf(clr_ovf), .din(din), .tx_start(tx_start),
        .tx_done_tick(tx_done_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_done();
        tx_done_tick = 1'b1;
        tick();
        tx_done_tick = 1'b0;
    endtask

    task automatic put(input logic [7:0] b);
        wr = 1'b1;
        w_data = b;
        tick();
        wr = 1'b0;
    endtask

    initial begin
        reset = 1'b0; wr = 1'b0; w_data = 8'h00; clr_ovf = 1'b0; tx_done_tick = 1'b0;

        // reset held
        repeat (10) tick();
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_din", din, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_tx_start", tx_start, 0);
            chk("idle_busy", busy, 0);
        end
        chk("idle_count", count, 0);

        // single byte
        put(8'hA5);
        chk("sb_count", count, 1);
        chk("sb_empty", empty, 0);
        chk("sb_nostart", tx_start, 0);
        tick();
        chk("sb_start", tx_start, 1);
        chk("sb_din", din, 8'hA5);
        chk("sb_busy", busy, 1);
        chk("sb_count0", count, 0);
        tick();
        chk("sb_start_off", tx_start, 0);
        repeat (5) tick();
        chk("sb_din_hold", din, 8'hA5);
        send_done();
        chk("sb_idle", busy, 0);
        tick();
        chk("sb_no_restart", tx_start, 0);
        chk("sb_empty_end", empty, 1);

        // ordered burst: byte 0 pops at the second write edge
        for (int i = 0; i < 16; i++) begin
            wr = 1'b1; w_data = 8'(i);
            tick();
            chk("burst_notfull", full, 0);
        end
        wr = 1'b0;
        chk("burst_count", count, 15);
        chk("burst_din0", din, 8'h00);
        chk("burst_busy", busy, 1);
        for (int k = 1; k < 16; k++) begin
            repeat (3) tick();
            send_done();
            chk("burst_gap_idle", tx_start, 0);
            tick();
            chk("burst_start", tx_start, 1);
            chk("burst_din", din, 8'(k));
            tick();
            chk("burst_start_1cyc", tx_start, 0);
        end
        send_done();
        tick();
        chk("burst_end_empty", empty, 1);
        chk("burst_end_start", tx_start, 0);

        // overflow with done held low
        for (int i = 0; i < 18; i++) begin
            wr = 1'b1; w_data = 8'(8'h30 + i);
            tick();
            if (i == 16) begin
                chk("ovf_full", full, 1);
                chk("ovf_count16", count, 16);
                chk("ovf_not_yet", overflow, 0);
            end
        end
        wr = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", overflow, 0);
        wr = 1'b1; w_data = 8'hEE; clr_ovf = 1'b1;
        tick();
        wr = 1'b0; clr_ovf = 1'b0;
        chk("ovf_set_wins", overflow, 1);
        chk("ovf_drop_count", count, 16);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr2", overflow, 0);
        chk("ovf_din_head", din, 8'h30);
        for (int k = 1; k <= 16; k++) begin
            send_done();
            tick();
            chk("ovf_drain_start", tx_start, 1);
            chk("ovf_drain_din", din, 8'(8'h30 + k));
            tick();
        end
        send_done();
        tick();
        chk("ovf_dropped_absent", tx_start, 0);
        chk("ovf_last_din", din, 8'h40);
        chk("ovf_empty", empty, 1);

        // concurrent fill while draining
        put(8'h55);
        tick();
        chk("cc_start", tx_start, 1);
        tick();
        put(8'hAA);
        chk("cc_count1", count, 1);
        put(8'hFF);
        chk("cc_count2", count, 2);
        chk("cc_din55", din, 8'h55);
        send_done();
        tick();
        chk("cc_dinAA", din, 8'hAA);
        chk("cc_startAA", tx_start, 1);
        chk("cc_countAA", count, 1);
        tick();
        send_done();
        tick();
        chk("cc_dinFF", din, 8'hFF);
        chk("cc_countFF", count, 0);
        tick();
        send_done();
        tick();
        chk("cc_end_busy", busy, 0);

        // spurious done in IDLE and START
        send_done();
        chk("sp_idle_busy", busy, 0);
        chk("sp_idle_start", tx_start, 0);
        put(8'h11);
        tick();
        chk("sp_in_start", tx_start, 1);
        send_done();
        chk("sp_start_ignored", busy, 1);
        tick();
        chk("sp_still_wait", busy, 1);

        // reset mid-frame with 4 queued
        for (int i = 0; i < 4; i++) put(8'(8'h60 + i));
        chk("mr_count4", count, 4);
        #2 reset = 1'b0;
        #1;
        chk("mr_count", count, 0);
        chk("mr_empty", empty, 1);
        chk("mr_busy", busy, 0);
        chk("mr_din", din, 8'h00);
        chk("mr_start", tx_start, 0);
        chk("mr_full", full, 0);
        repeat (2) tick();
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("mr_no_start", tx_start, 0);
        end
        chk("mr_still_empty", empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Transmit-side buffer and sequencer that sits directly upstream of `uart_tx`. It accepts bytes from the host through a single-cycle write strobe and stores them in a FIFO of depth 2^ADDR_WIDTH. It presents one byte at a time on `din`, pulses `tx_start`, and waits for `tx_done_tick` before launching the next byte. The host can therefore queue a burst without tracking per-frame UART timing.

## Interface
- `DBITS`, default 8: data word width; must match `uart_tx` DBITS.
- `ADDR_WIDTH`, default 4: FIFO address width; depth = 2^ADDR_WIDTH (16).
- `clk`, input, 1: system clock; all state updates on rising edge.
- `reset`, input, 1: asynchronous, active-low reset. Asserting it (0) clears all state immediately, independent of `clk`.
- `wr`, input, 1: write strobe; one byte is offered per cycle in which `wr`=1.
- `w_data`, input, DBITS: byte to enqueue; sampled when `wr`=1.
- `full`, output, 1: FIFO holds 2^ADDR_WIDTH entries.
- `empty`, output, 1: FIFO holds 0 entries.
- `count`, output, ADDR_WIDTH+1: current occupancy, 0..2^ADDR_WIDTH.
- `overflow`, output, 1: sticky flag; set when a write is attempted while `full`=1.
- `clr_ovf`, input, 1: synchronous clear of `overflow`.
- `din`, output, DBITS: byte presented to `uart_tx.din`; registered.
- `tx_start`, output, 1: one-cycle start pulse to `uart_tx.tx_start`; registered.
- `tx_done_tick`, input, 1: frame-complete pulse from `uart_tx`.
- `busy`, output, 1: high whenever the sequencer is not in IDLE.

## Operation
- Storage and pointers:
  - Circular buffer with ADDR_WIDTH-bit read and write pointers; both wrap modulo 2^ADDR_WIDTH.
  - `count` is a separate ADDR_WIDTH+1-bit counter.
  - `full` = (`count`==2^ADDR_WIDTH); `empty` = (`count`==0).
- Write rules:
  - A write is accepted when `wr`=1 and `full`=0.
  - `full` is the registered value from the start of the cycle. A pop in the same cycle does not make room for a write to a full FIFO; that write is dropped and sets `overflow`.
- Pop and write in the same cycle with a non-full, non-empty FIFO: both occur and `count` is unchanged.
- A write to an empty FIFO cannot be popped in the same cycle. `empty` is registered, so the earliest pop is on the next edge.
- `overflow` priority:
  - If a set condition and `clr_ovf` occur in the same cycle, set wins.
  - Dropped data never disturbs stored entries.
- Sequencer states:
  - IDLE, default state: if `empty`=0, pop the head entry into `din` and go to START. Otherwise stay in IDLE.
  - START: `tx_start`=1 for exactly this one cycle, then go to WAIT.
  - WAIT: stay until `tx_done_tick`=1, then go to IDLE.
- `tx_done_tick` in IDLE or START is ignored.
- `din` holds the last popped byte until the next pop. It is never changed while in START or WAIT.
- `busy` = (state != IDLE).

## Timing
- Reset values, while `reset`=0 and after release:
  - state = IDLE.
  - `din`=0, `tx_start`=0, `busy`=0, `overflow`=0.
  - `count`=0, `empty`=1, `full`=0.
  - Pointers = 0.
- Reset mid-operation: the FIFO contents are discarded and all of the reset values above apply at once. `uart_tx` shares the same reset, so any frame in progress is aborted.
- Write latency:
  - A write sampled at edge E updates `count` and `empty` after E.
  - With the sequencer in IDLE, the pop occurs at edge E+1, updating `din` and moving to START.
  - `tx_start` is high from E+1 to E+2.
  - From `wr` to `tx_start`, latency is 1 cycle after the accepting edge.
- Back-to-back frames:
  - `tx_done_tick` sampled at edge D returns the sequencer to IDLE.
  - If the FIFO is non-empty, the pop occurs at D+1 and `tx_start` is high from D+1 to D+2.
  - Gap between frames is 2 cycles.
- `tx_start` is never high for more than one consecutive cycle. It is never asserted while `uart_tx` is between `tx_start` and `tx_done_tick`.

## Test plan
- Reset check: hold `reset`=0 for 10 cycles -> `empty`=1, `count`=0, `tx_start`=0, `din`=0x00, `busy`=0. Release reset and run 20 idle cycles -> no change.
- Single byte: write 0xA5 in loopback with `uart_tx`/`uart_rx` and `dvsr`=20 -> one `tx_start` pulse 1 cycle after the write edge. The receiver's `dout`=0xA5, then `busy`=0 and `empty`=1.
- Ordered burst: write 0x00..0x0F in 16 consecutive cycles -> after the 16th write, `count`=15 (one byte already popped) and never reaches `full`. The receiver gets 0x00..0x0F in order, with exactly 16 `tx_start` pulses, each separated by `tx_done_tick` + 2 cycles.
- Overflow: with `tx_done_tick` held at 0, write 18 bytes -> first byte popped, `count`=16, `full`=1, and `overflow`=1 on the 18th write. Then assert `clr_ovf` -> `overflow`=0. Release `tx_done_tick` -> the 17 stored bytes are sent in order; the dropped 18th byte is absent.
- Concurrent fill while draining: write 0x55, and while in WAIT write 0xAA, 0xFF in consecutive cycles -> `count` goes 1, 2, and the received sequence is 0x55, 0xAA, 0xFF.
- Spurious done and reset mid-frame: pulse `tx_done_tick` in IDLE -> no state change. Queue 4 bytes and assert `reset` mid-frame -> the reset values apply immediately. After release, with no writes, no `tx_start` occurs.
